// File: rtl/count_checker.sv
// Checks that accepted count samples step by +1 (mod 2^WIDTH); reports lock, error pulse and saturating error tally.
// All outputs registered, one cycle after the deciding sample; no backpressure (every in_valid sample is consumed).
module count_checker #(
  parameter int WIDTH         = 8,
  parameter int LOCK_COUNT    = 4,
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         cnt_in,
  input  logic                     clr_err,
  output logic                     locked,
  output logic                     err_pulse,
  output logic [ERR_CNT_WIDTH-1:0] err_count,
  output logic [WIDTH-1:0]         expected
);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCK} state_t;

  localparam logic [3:0]               LOCK_RUN = 4'(LOCK_COUNT);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX  = '1;

  state_t     state;
  logic [3:0] run;
  logic [3:0] run_nxt;
  logic       match;
  logic       err_hit;

  assign match   = (cnt_in == expected);
  assign err_hit = in_valid && (state == LOCK) && !match;
  assign run_nxt = run + 4'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SEARCH;
      run       <= 4'd0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      expected  <= '0;
    end else begin
      err_pulse <= err_hit;

      // Clear takes effect before a same-edge increment, so a colliding error leaves a count of 1.
      if (clr_err)
        err_count <= err_hit ? ERR_CNT_WIDTH'(1) : '0;
      else if (err_hit && err_count != ERR_MAX)
        err_count <= err_count + ERR_CNT_WIDTH'(1);

      if (in_valid) begin
        expected <= cnt_in + WIDTH'(1);
        case (state)
          SEARCH: begin
            run   <= 4'd1;
            state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (match) begin
              run <= run_nxt;
              if (run_nxt == LOCK_RUN) begin
                state  <= LOCK;
                locked <= 1'b1;
              end
            end else begin
              run <= 4'd1;
            end
          end
          LOCK: begin
            // A break seeds a fresh run with the offending sample.
            if (!match) begin
              run    <= 4'd1;
              state  <= ACQUIRE;
              locked <= 1'b0;
            end
          end
          default: begin
            run    <= 4'd0;
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_count_checker.sv
// Directed bench for count_checker: lock, wrap, glitch, gaps, saturation, clear/reset collisions.
module tb_count_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] cnt_in;
  logic       clr_err;

  logic       locked,   locked_s;
  logic       err_pulse, err_pulse_s;
  logic [7:0] err_count;
  logic [1:0] err_count_s;
  logic [7:0] expected, expected_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  count_checker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cnt_in(cnt_in), .clr_err(clr_err),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .expected(expected)
  );

  // Same stimulus, narrow error counter for saturation checks.
  count_checker #(.WIDTH(8), .LOCK_COUNT(4), .ERR_CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .cnt_in(cnt_in), .clr_err(clr_err),
    .locked(locked_s), .err_pulse(err_pulse_s), .err_count(err_count_s), .expected(expected_s)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] c);
    in_valid = v;
    cnt_in   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic feed_ok(input string tag, input logic [7:0] c, input logic exp_locked);
    step(1'b1, c);
    chk($sformatf("%s_pulse_%0d", tag, c), err_pulse, 1'b0);
    chk($sformatf("%s_locked_%0d", tag, c), locked, exp_locked);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; cnt_in = 8'd9; clr_err = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_locked", locked, 1'b0);
    chk("rst_pulse", err_pulse, 1'b0);
    chk("rst_errcnt", err_count, 8'd0);
    chk("rst_expected", expected, 8'd0);
    rst = 1'b0; clr_err = 1'b0;

    // 1: basic lock
    feed_ok("lock", 8'd0, 1'b0);
    chk("lock_exp0", expected, 8'd1);
    feed_ok("lock", 8'd1, 1'b0);
    feed_ok("lock", 8'd2, 1'b0);
    feed_ok("lock", 8'd3, 1'b1);
    chk("lock_exp3", expected, 8'd4);
    chk("lock_errcnt", err_count, 8'd0);

    // 2: wrap; reset and lock with expected=250 first
    rst = 1'b1; step(1'b0, 8'd0); rst = 1'b0;
    for (int i = 246; i <= 249; i++) feed_ok("prewrap", 8'(i), i == 249);
    chk("prewrap_exp", expected, 8'd250);
    for (int i = 250; i <= 258; i++) feed_ok("wrap", 8'(i), 1'b1);
    chk("wrap_exp", expected, 8'd3);

    // 3: glitch
    for (int i = 3; i <= 11; i++) feed_ok("preglitch", 8'(i), 1'b1);
    step(1'b1, 8'd99);
    chk("glitch_pulse", err_pulse, 1'b1);
    chk("glitch_locked", locked, 1'b0);
    chk("glitch_errcnt", err_count, 8'd1);
    chk("glitch_exp", expected, 8'd100);
    feed_ok("relock", 8'd100, 1'b0);
    feed_ok("relock", 8'd101, 1'b0);
    feed_ok("relock", 8'd102, 1'b1);
    chk("relock_errcnt", err_count, 8'd1);

    // 4: gaps
    rst = 1'b1; step(1'b0, 8'd0); rst = 1'b0;
    chk("gap_rst_errcnt", err_count, 8'd0);
    feed_ok("gap", 8'd5, 1'b0);
    feed_ok("gap", 8'd6, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'd77);
      chk($sformatf("gap_idle_exp_%0d", i), expected, 8'd7);
      chk($sformatf("gap_idle_pulse_%0d", i), err_pulse, 1'b0);
    end
    feed_ok("gap", 8'd7, 1'b0);
    feed_ok("gap", 8'd8, 1'b1);
    chk("gap_exp", expected, 8'd9);

    // 5: saturation (expected=9 going in, 204 after each relock)
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 8'd200);
      chk($sformatf("sat_pulse_%0d", k), err_pulse_s, 1'b1);
      chk($sformatf("sat_cnt_%0d", k), err_count_s, (k < 3) ? k + 1 : 3);
      chk($sformatf("sat_wide_cnt_%0d", k), err_count, k + 1);
      step(1'b1, 8'd201);
      chk($sformatf("sat_pulse_off_%0d", k), err_pulse_s, 1'b0);
      step(1'b1, 8'd202);
      step(1'b1, 8'd203);
      chk($sformatf("sat_relock_%0d", k), locked_s, 1'b1);
    end

    // 6: clear colliding with an error, then clear alone
    clr_err = 1'b1;
    step(1'b1, 8'd50);
    chk("clr_hit_cnt", err_count, 8'd1);
    chk("clr_hit_cnt_s", err_count_s, 2'd1);
    chk("clr_hit_pulse", err_pulse, 1'b1);
    chk("clr_hit_locked", locked, 1'b0);
    step(1'b0, 8'd0);
    chk("clr_only_cnt", err_count, 8'd0);
    clr_err = 1'b0;
    feed_ok("acq", 8'd51, 1'b0);
    // reset during ACQUIRE (run=2); the sample on that edge is discarded
    rst = 1'b1;
    step(1'b1, 8'd52);
    rst = 1'b0;
    chk("midrst_locked", locked, 1'b0);
    chk("midrst_errcnt", err_count, 8'd0);
    chk("midrst_exp", expected, 8'd0);
    chk("midrst_pulse", err_pulse, 1'b0);
    feed_ok("post", 8'd40, 1'b0);
    feed_ok("post", 8'd41, 1'b0);
    feed_ok("post", 8'd42, 1'b0);
    feed_ok("post", 8'd43, 1'b1);
    chk("post_exp", expected, 8'd44);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
